// File: rtl/wb_arbiter.sv
// Writeback arbiter and pending-write scoreboard for the 32x32 register file.
// Define WB_BYPASS_EN to clear busy and raise fwd for a source being written this cycle.
module wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rs1_fwd,
    output logic        rs2_fwd,
    output logic        rf_we,
    output logic [4:0]  rf_wraddr,
    output logic [31:0] rf_wrdata
);

    logic [3:0]  starve_cnt;
    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic        force_alu;
    logic        accept;
    logic [4:0]  acc_addr;
    logic [31:0] acc_data;
    logic        rs1_hit;
    logic        rs2_hit;

    // Load wins unless the ALU has already waited STARVE_MAX load grants.
    always_comb begin
        force_alu = alu_valid && (starve_cnt == 4'(STARVE_MAX));
        ld_ready  = ld_valid && !force_alu;
        alu_ready = alu_valid && !ld_ready;
        accept    = ld_ready || alu_ready;
        acc_addr  = ld_ready ? ld_addr : alu_addr;
        acc_data  = ld_ready ? ld_data : alu_data;
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        busy_d = busy_q;
        if (rf_we && (rf_wraddr != 5'd0))
            busy_d[rf_wraddr] = 1'b0;
        // The set follows the clear so a same-cycle reservation wins.
        if (rsv_valid && (rsv_addr != 5'd0))
            busy_d[rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            rf_we      <= 1'b0;
            rf_wraddr  <= 5'd0;
            rf_wrdata  <= 32'd0;
            busy_q     <= 32'd0;
        end else begin
            if (!alu_valid || alu_ready)
                starve_cnt <= 4'd0;
            else if (ld_ready)
                starve_cnt <= starve_cnt + 4'd1;

            // x0 completes the handshake but never produces a write.
            rf_we <= accept && (acc_addr != 5'd0);
            if (accept) begin
                rf_wraddr <= acc_addr;
                rf_wrdata <= acc_data;
            end

            busy_q <= busy_d;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs1_hit = rf_we && (rf_wraddr == rs1) && (rs1 != 5'd0);
    assign rs2_hit = rf_we && (rf_wraddr == rs2) && (rs2 != 5'd0);
`else
    assign rs1_hit = 1'b0;
    assign rs2_hit = 1'b0;
`endif

    assign rs1_busy = busy_q[rs1] && !rs1_hit;
    assign rs2_busy = busy_q[rs2] && !rs2_hit;
    assign rs1_fwd  = rs1_hit;
    assign rs2_fwd  = rs2_hit;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and pending-write scoreboard for the 32x32 register file. It arbitrates two writeback sources onto the file's single write port: the ALU result path and the load-data path. It also tracks which destination registers have an outstanding write, so issue logic can stall on read-after-write hazards. It sits between the execute/memory stages and the register file, and drives the file's write-enable, write-address and write-data inputs from registers.

## Interface
- STARVE_MAX, 4, number of consecutive load grants while ALU is waiting before ALU is forced; legal 1..15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- ld_valid  in  1  load writeback request
- ld_addr  in  5  load destination register
- ld_data  in  32  load data
- ld_ready  out  1  load request accepted this cycle
- rsv_valid  in  1  issue stage reserves a destination register
- rsv_addr  in  5  register being reserved
- rs1, rs2  in  5  source registers to check
- rs1_busy, rs2_busy  out  1  source has a pending write
- rs1_fwd, rs2_fwd  out  1  source may take rf_wrdata this cycle (see Configuration)
- rf_we  out  1  register-file write enable (registered)
- rf_wraddr  out  5  register-file write address (registered)
- rf_wrdata  out  32  register-file write data (registered)

## Operation
- Handshake: a request is accepted in a cycle where valid && ready. At most one acceptance per cycle. ready is combinational from the valids and starve_cnt. A requester must hold valid/addr/data stable until accepted, and valid must not depend on ready.
- Arbitration: load has priority. force_alu = alu_valid && (starve_cnt == STARVE_MAX).
  - ld_ready = ld_valid && !force_alu
  - alu_ready = alu_valid && !ld_ready
- starve_cnt (4 bits):
  - increments when alu_valid && ld_ready;
  - clears when alu_ready, or when !alu_valid;
  - otherwise holds.
- Accepted request → registered writeback:
  - next cycle rf_we=1 and rf_wraddr/rf_wrdata = the accepted addr/data;
  - if the accepted addr is 0, rf_we=0 (x0 is never written, but the handshake still completes).
  - No accept → rf_we=0, and addr/data hold their previous values.
- Scoreboard: 32-bit busy mask; bit 0 is constant 0.
  - Set on rsv_valid for rsv_addr≠0.
  - Cleared at the edge where rf_we=1 for that address.
  - Simultaneous set and clear of the same bit: set wins.
  - Reserving an already-busy register leaves it busy (single bit, no counting).
- rsN_busy = mask[rsN], combinational. rsN=0 → busy=0.

## Timing
- Accept in cycle N → rf_we high in N+1 → register file updated at the end of N+1 → scoreboard bit clear from N+2.
- Without the bypass feature, a dependent read sees the new value and busy=0 in N+2.
- Reset values: rf_we=0, rf_wraddr=0, rf_wrdata=0, busy mask=0, starve_cnt=0.
  - ready and busy outputs follow from these.
  - The fwd outputs are 0 while the mask and rf_we are 0.
- Reset mid-operation:
  - a writeback registered before reset is dropped (rf_we=0 the cycle after rst);
  - all reservations are lost.
  - The pipeline must flush alongside.
- Back-to-back accepts are sustained at one write per cycle.

## Configuration
- WB_BYPASS_EN defined: in a cycle where rf_we=1 and rf_wraddr==rsN≠0:
  - rsN_busy=0 and rsN_fwd=1;
  - the consumer takes rf_wrdata instead of the file output.
  - This saves one stall cycle.
- WB_BYPASS_EN undefined:
  - rs1_fwd=rs2_fwd=0 constantly;
  - busy strictly follows the mask.

## Test plan
- Reset, then reserve x5 → rs1=5 gives busy=1. ALU writes x5=0x20 → rf_we, wraddr=5, wrdata=0x20 one cycle after accept. busy=0 two cycles after accept (bypass off), or busy=0 and fwd=1 in the rf_we cycle (bypass on).
- alu_valid and ld_valid both held high, STARVE_MAX=4 → grant sequence ld,ld,ld,ld,alu,ld,ld,ld,ld,alu…
- Only alu_valid high → alu_ready same cycle. Write to x0 accepted → rf_we stays 0 and the x0 mask stays 0.
- Reserve x7 in the same cycle rf_we=1 with wraddr=7 → x7 remains busy.
- Reserve x3 and accept a load to x3, then assert rst in the cycle after the accept → rf_we=0 the following cycle, busy mask=0, starve_cnt=0.
- Consecutive load accepts to x1,x2,x3 → rf_we high three consecutive cycles with matching addresses and data.
